memory_responder: RTL and testbench

Data-memory slave that answers the control unit's MOV/RW/MOC memory handshake. It latches a request when MOV rises and inserts a programmable number of wait states. It then performs a big-endian byte, halfword or word read or write on an internal byte array and raises MOC until the initiator drops MOV. It sits on the datapath memory port, fed by MAR (address) and MDR (write data), and returns read data to MDR.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/ram_byte_array.sv | 30 +++
 rtl/memory_responder.sv | 154 +++++++++++++++
 tb/tb_memory_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory responder: transfer sizes, direction and FSM states.
// Also holds the alignment/size error rule used at the access step.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_BUSY    = 2'd1;
  localparam state_t ST_ACK     = 2'd2;
  localparam state_t ST_RELEASE = 2'd3;

  // Reserved size, or halfword/word not on its natural boundary.
  function automatic logic reqError(input logic [1:0] size, input logic [1:0] lowAddr);
    return (size == SZ_RSVD) ||
           ((size == SZ_HALF) && lowAddr[0]) ||
           ((size == SZ_WORD) && (lowAddr != 2'b00));
  endfunction

endpackage

// File: rtl/ram_byte_array.sv
// Byte-addressed storage with a 4-lane window starting at addr_i (wrapping at the top).
// Lane 0 is the byte at addr_i and sits in bits [31:24]; writes are clocked, reads are combinational.
module ram_byte_array #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [3:0]            we_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [7:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[3-i]) begin
        mem_q[addr_i + ADDR_WIDTH'(i)] <= wdata_i[31-8*i -: 8];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < 4; i++) begin
      rdata_o[31-8*i -: 8] = mem_q[addr_i + ADDR_WIDTH'(i)];
    end
  end

endmodule

// File: rtl/memory_responder.sv
// MOV/RW/MOC memory slave: captures a request, waits WAIT_STATES cycles, performs a
// big-endian byte/halfword/word access and holds MOC until the initiator drops MOV.
module memory_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  Size,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC,
  output logic        ERR
);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rw_q, rw_d;
  logic [1:0]            size_q, size_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           dout_q, dout_d;
  logic                  moc_q, moc_d;
  logic                  err_q, err_d;

  logic [31:0] ramRdata;
  logic [31:0] ramWdata;
  logic [31:0] rdValue;
  logic [3:0]  laneMask;
  logic [3:0]  ramWe;
  logic        badReq;
  logic        unusedAddrBits;

  assign unusedAddrBits = ^Address[31:ADDR_WIDTH];
  assign badReq         = reqError(size_q, addr_q[1:0]);

  // Lane steering: narrow writes land in the leading lanes, narrow reads come from them.
  always_comb begin
    laneMask = 4'b1111;
    ramWdata = wdata_q;
    rdValue  = ramRdata;
    case (size_q)
      SZ_BYTE: begin
        laneMask = 4'b1000;
        ramWdata = {wdata_q[7:0], 24'h0};
        rdValue  = {24'h0, ramRdata[31:24]};
      end
      SZ_HALF: begin
        laneMask = 4'b1100;
        ramWdata = {wdata_q[15:0], 16'h0};
        rdValue  = {16'h0, ramRdata[31:16]};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    moc_d   = moc_q;
    err_d   = err_q;
    ramWe   = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (MOV) begin
          rw_d    = RW;
          size_d  = Size;
          addr_d  = Address[ADDR_WIDTH-1:0];
          wdata_d = DataIn;
          cnt_d   = 4'(WAIT_STATES);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!MOV) begin
          state_d = ST_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_ACK;
          moc_d   = 1'b1;
          err_d   = badReq;
          if (!badReq) begin
            if (rw_q == RW_READ) begin
              dout_d = rdValue;
            end else begin
              ramWe = laneMask;
            end
          end
        end
      end
      ST_ACK, ST_RELEASE: begin
        // Stay acknowledged until MOV is seen low so one pulse serves exactly one request.
        if (!MOV) begin
          state_d = ST_IDLE;
          moc_d   = 1'b0;
          err_d   = 1'b0;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= RW_READ;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      moc_q   <= moc_d;
      err_q   <= err_d;
    end
  end

  ram_byte_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .addr_i (addr_q),
    .we_i   (ramWe),
    .wdata_i(ramWdata),
    .rdata_o(ramRdata)
  );

  assign DataOut = dout_q;
  assign MOC     = moc_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: two instances (WAIT_STATES=2 and 0) share the request inputs
// but have separate MOV lines; results are checked against a byte-array reference model.
module tb_memory_responder;
  import mem_pkg::*;

  logic        clk;
  logic        reset;
  logic        RW;
  logic [1:0]  Size;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic        movW0, movW2;
  logic [31:0] doutW0, doutW2;
  logic        mocW0, mocW2;
  logic        errW0, errW2;

  int nChecks;
  int nFails;

  logic [7:0]  modelMem [2][512];
  logic [31:0] modelDout [2];

  typedef struct {
    logic        rw;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] expD;
    logic        expE;
  } vec_t;

  vec_t vecs [15];

  memory_responder #(.ADDR_WIDTH(9), .WAIT_STATES(2)) dutW2 (
    .clk(clk), .reset(reset), .MOV(movW2), .RW(RW), .Size(Size), .Address(Address),
    .DataIn(DataIn), .DataOut(doutW2), .MOC(mocW2), .ERR(errW2)
  );

  memory_responder #(.ADDR_WIDTH(9), .WAIT_STATES(0)) dutW0 (
    .clk(clk), .reset(reset), .MOV(movW0), .RW(RW), .Size(Size), .Address(Address),
    .DataIn(DataIn), .DataOut(doutW0), .MOC(mocW0), .ERR(errW0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic curMoc(input int inst);
    return (inst == 0) ? mocW0 : mocW2;
  endfunction

  function automatic logic curErr(input int inst);
    return (inst == 0) ? errW0 : errW2;
  endfunction

  function automatic logic [31:0] curDout(input int inst);
    return (inst == 0) ? doutW0 : doutW2;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour: wrap the address, reject reserved/misaligned, move n bytes MSB-first.
  task automatic modelReq(input int inst, input logic rw, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] data,
                          output logic [31:0] expD, output logic expE);
    int a;
    int n;
    logic [31:0] v;
    a = int'(addr % 512);
    n = 1 << sz;
    expE = (sz == 2'd3) || ((a % n) != 0);
    if (!expE) begin
      if (rw == RW_READ) begin
        v = 0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(modelMem[inst][(a + i) % 512]);
        modelDout[inst] = v;
      end else begin
        for (int i = 0; i < n; i++) modelMem[inst][(a + i) % 512] = 8'(data >> (8 * (n - 1 - i)));
      end
    end
    expD = modelDout[inst];
  endtask

  task automatic setMov(input int inst, input logic v);
    if (inst == 0) movW0 = v;
    else movW2 = v;
  endtask

  // One full handshake; after capture the request inputs are scrambled to a decoy write.
  task automatic applyStimulus(input int inst, input logic rw, input logic [1:0] sz,
                               input logic [31:0] addr, input logic [31:0] data, input int hold,
                               output logic [31:0] dout, output logic err, output int lat);
    @(negedge clk);
    RW = rw; Size = sz; Address = addr; DataIn = data;
    setMov(inst, 1'b1);
    @(posedge clk); #1;
    RW = RW_WRITE; Size = SZ_WORD;
    Address = 32'($urandom_range(0, 15) * 4); DataIn = $urandom;
    lat = 0;
    while (!curMoc(inst) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    dout = curDout(inst);
    err  = curErr(inst);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput("MOC held", 32'(curMoc(inst)), 32'd1);
    end
    setMov(inst, 1'b0);
    @(posedge clk); #1;
    checkOutput("MOC after release", 32'(curMoc(inst)), 32'd0);
    checkOutput("ERR after release", 32'(curErr(inst)), 32'd0);
  endtask

  task automatic checkedReq(input int inst, input logic rw, input logic [1:0] sz,
                            input logic [31:0] addr, input logic [31:0] data, input int hold);
    logic [31:0] expD, dout;
    logic        expE, err;
    int          lat;
    modelReq(inst, rw, sz, addr, data, expD, expE);
    applyStimulus(inst, rw, sz, addr, data, hold, dout, err, lat);
    checkOutput("latency", 32'(lat), (inst == 0) ? 32'd1 : 32'd3);
    checkOutput("DataOut", dout, expD);
    checkOutput("ERR", 32'(err), 32'(expE));
  endtask

  initial begin
    logic [31:0] expD, dout, r;
    logic        expE, err, sawMoc;
    logic [1:0]  sz;
    int          lat, pick;

    nChecks = 0;
    nFails  = 0;
    modelDout[0] = '0;
    modelDout[1] = '0;
    movW0 = 0; movW2 = 0; RW = RW_READ; Size = SZ_WORD; Address = '0; DataIn = '0;

    vecs[0]  = '{RW_WRITE, SZ_WORD, 32'h010, 32'h1234ABCD, 32'h00000000, 1'b0};
    vecs[1]  = '{RW_READ,  SZ_WORD, 32'h010, 32'h0,        32'h1234ABCD, 1'b0};
    vecs[2]  = '{RW_READ,  SZ_BYTE, 32'h010, 32'h0,        32'h00000012, 1'b0};
    vecs[3]  = '{RW_READ,  SZ_BYTE, 32'h013, 32'h0,        32'h000000CD, 1'b0};
    vecs[4]  = '{RW_READ,  SZ_HALF, 32'h012, 32'h0,        32'h0000ABCD, 1'b0};
    vecs[5]  = '{RW_WRITE, SZ_BYTE, 32'h011, 32'hFF,       32'h0000ABCD, 1'b0};
    vecs[6]  = '{RW_READ,  SZ_WORD, 32'h010, 32'h0,        32'h12FFABCD, 1'b0};
    vecs[7]  = '{RW_WRITE, SZ_WORD, 32'h012, 32'hDEADBEEF, 32'h12FFABCD, 1'b1};
    vecs[8]  = '{RW_READ,  SZ_WORD, 32'h010, 32'h0,        32'h12FFABCD, 1'b0};
    vecs[9]  = '{RW_READ,  SZ_HALF, 32'h011, 32'h0,        32'h12FFABCD, 1'b1};
    vecs[10] = '{RW_READ,  SZ_RSVD, 32'h010, 32'h0,        32'h12FFABCD, 1'b1};
    vecs[11] = '{RW_WRITE, SZ_WORD, 32'h20C, 32'hCAFEF00D, 32'h12FFABCD, 1'b0};
    vecs[12] = '{RW_READ,  SZ_WORD, 32'h00C, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[13] = '{RW_READ,  SZ_BYTE, 32'h20F, 32'h0,        32'h0000000D, 1'b0};
    vecs[14] = '{RW_READ,  SZ_WORD, 32'hFFFFF00C, 32'h0,   32'hCAFEF00D, 1'b0};

    reset = 1'b1;
    #1;
    checkOutput("reset MOC W2", 32'(mocW2), 32'd0);
    checkOutput("reset ERR W2", 32'(errW2), 32'd0);
    checkOutput("reset DataOut W2", doutW2, 32'd0);
    checkOutput("reset MOC W0", 32'(mocW0), 32'd0);
    checkOutput("reset DataOut W0", doutW0, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 15; v++) begin
      modelReq(1, vecs[v].rw, vecs[v].sz, vecs[v].addr, vecs[v].data, expD, expE);
      applyStimulus(1, vecs[v].rw, vecs[v].sz, vecs[v].addr, vecs[v].data, 0, dout, err, lat);
      checkOutput($sformatf("vec%0d latency", v), 32'(lat), 32'd3);
      checkOutput($sformatf("vec%0d DataOut", v), dout, vecs[v].expD);
      checkOutput($sformatf("vec%0d ERR", v), 32'(err), 32'(vecs[v].expE));
    end

    // Abort: write dropped while waiting must not complete or commit.
    @(negedge clk);
    RW = RW_WRITE; Size = SZ_WORD; Address = 32'h010; DataIn = 32'h55555555; movW2 = 1'b1;
    @(posedge clk); #1;
    movW2 = 1'b0;
    sawMoc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      sawMoc = sawMoc | mocW2;
    end
    checkOutput("abort MOC never rose", 32'(sawMoc), 32'd0);
    checkedReq(1, RW_READ, SZ_WORD, 32'h010, 32'h0, 0);

    // Reset while busy: outputs clear, the pending write is discarded.
    @(negedge clk);
    RW = RW_WRITE; Size = SZ_WORD; Address = 32'h010; DataIn = 32'h66666666; movW2 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midreset MOC", 32'(mocW2), 32'd0);
    checkOutput("midreset ERR", 32'(errW2), 32'd0);
    checkOutput("midreset DataOut", doutW2, 32'd0);
    movW2 = 1'b0;
    modelDout[0] = '0;
    modelDout[1] = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkedReq(1, RW_READ, SZ_WORD, 32'h010, 32'h0, 0);

    for (int inst = 0; inst < 2; inst++)
      for (int w = 0; w < 16; w++)
        checkedReq(inst, RW_WRITE, SZ_WORD, 32'(w * 4), $urandom, 0);

    // MOV held past ACK: one write only, then sweep the region for stray writes.
    checkedReq(1, RW_WRITE, SZ_WORD, 32'h020, 32'h01020304, 5);
    for (int w = 0; w < 16; w++) checkedReq(1, RW_READ, SZ_WORD, 32'(w * 4), 32'h0, 0);

    for (int inst = 0; inst < 2; inst++) begin
      for (int i = 0; i < 40; i++) begin
        pick = $urandom_range(0, 9);
        sz = (pick < 3) ? SZ_BYTE : (pick < 6) ? SZ_HALF : (pick < 9) ? SZ_WORD : SZ_RSVD;
        r = $urandom;
        checkedReq(inst, 1'($urandom_range(0, 1)), sz, {r[31:9], 3'b000, r[5:0]},
                   $urandom, $urandom_range(0, 2));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
